fp_seq_unit: RTL and testbench
==============================

Name: fp_seq_unit

Overview:
Multi-cycle IEEE-754 single-precision FADD/FSUB/FMUL unit for the floating-point core. It time-shares one 26-bit mantissa adder and one shifter across all ops under an FSM, trading latency for area on the Basys FPGA. The core issues an op with a start pulse, stalls on busy, and captures the result on done.

Parameters:
ALIGN_CAP, 26, maximum right-alignment shifts; a larger exponent difference is clamped to this value.
MUL_STEPS, 24, shift-add iterations for the mantissa product (hidden bit + 23).

Ports:
clk  in  1  system clock (divided clock in the board top)
reset  in  1  synchronous, active-high
start  in  1  request strobe, sampled only in IDLE
op  in  2  00 add, 01 sub, 10 mul, 11 reserved
a  in  32  operand A (IEEE-754 single)
b  in  32  operand B
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse, result valid
result  out  32  held stable from done until the next accepted start
flags  out  3  {invalid, overflow, underflow}; updated together with result

Behaviour:
- Reset (sync, active-high, any state): state=IDLE, busy=0, done=0, result=32'h0, flags=3'b0. An in-flight op is dropped.
- Start handling: start is accepted only in IDLE. Start while busy or in the DONE cycle is ignored; no queueing.
- States and transitions:
  - IDLE -> UNPACK on start. Latch a, b and op.
  - UNPACK: classify zero/inf/NaN; flush denormals to signed zero; add hidden bit. A special case goes to PACK. Add/sub goes to ALIGN, or to ADD if d=0. Mul goes to MUL.
  - ALIGN: shift the smaller-exponent mantissa right 1 bit per cycle, d=min(|ea-eb|, ALIGN_CAP) cycles. Shifted-out bits are discarded.
  - ADD: one cycle of effective add/sub; sub flips B's sign.
    - Carry out: shift right 1, exponent+1, in the same cycle.
    - Zero sum: result +0, go to PACK.
    - Otherwise go to NORM.
  - MUL: MUL_STEPS shift-add cycles into a 48-bit product; exponent = ea+eb-127; then go to NORM.
  - NORM: one check cycle plus k left shifts, 1 bit/cycle, until bit23=1. Also stops if the exponent reaches 0; that case is underflow and gives signed zero. A mul product of [2,4) takes 1 right shift inside the check cycle.
  - PACK: truncate (round toward zero), saturate, assemble the result -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- Latency L (start edge to the done cycle):
  - add/sub: L = 4 + d + k
  - zero sum: L = 4 + d
  - mul: L = 4 + MUL_STEPS = 28
  - special case: L = 3
- Special-case results:
  - Any NaN operand, inf-inf (effective), inf*0, or op=11: result 32'h7FC00000, invalid=1.
  - inf op finite: signed inf.
  - Exponent >= 255 after PACK: signed inf, overflow=1.
  - Exponent <= 0: signed zero, underflow=1.
  - x - x: +0.
  - Mul sign = sa^sb.
- Width rules: the working mantissa is 26 bits (carry + hidden + 23 + guard unused). The working exponent is signed 10-bit so over/underflow can be detected.

Decomposition:
- Package fp_pkg holds:
  - op codes OP_ADD, OP_SUB, OP_MUL
  - QNAN=32'h7FC00000, BIAS=127
  - state encoding
  - flag bit indices
- One natural sub-module is fp_classify, a combinational unpack/classify per operand: sign, exp, mant, is_zero, is_inf, is_nan. It is instantiated twice.

Test Plan:
- Add, 1.0+1.0: a=3F800000, b=3F800000, op=00 -> result 40000000, flags 000, done at L=4, busy high cycles 1-3.
- Sub with normalization: a=3F800000, b=3F400000, op=01 -> result 3E800000 (0.25), d=1, k=2, L=7.
- Mul: a=3FC00000 (1.5), b=40000000, op=10 -> result 40400000 (3.0), L=28. Assert start mid-op -> ignored, and result stays held after done until the next start.
- Specials:
  - 7F800000 - 7F800000 -> 7FC00000, invalid, L=3.
  - 7F800000 * 00000000 -> 7FC00000, invalid.
  - 7F000000 * 40000000 -> 7F800000, overflow.
- Align clamp: a=3F800000, b=30800000 (2^-30), op=00 -> result 3F800000, d=26, L=30. Also 00800000 * 00800000 -> 00000000, underflow.
- Reset mid-mul at cycle 10: reset=1 for one edge -> next cycle busy=0, done=0, result=0, flags=0. A new start then completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential single-precision FADD/FSUB/FMUL unit:
// op codes, IEEE constants, FSM encoding and flag bit positions.
package fp_pkg;

  localparam int ALIGN_CAP_DEF = 26;
  localparam int MUL_STEPS_DEF = 24;
  localparam int BIAS          = 127;

  localparam logic [1:0]  OP_ADD = 2'b00;
  localparam logic [1:0]  OP_SUB = 2'b01;
  localparam logic [1:0]  OP_MUL = 2'b10;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  // flags = {invalid, overflow, underflow}
  localparam int FLG_INV = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_MUL, S_NORM, S_PACK, S_DONE
  } state_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack of one IEEE-754 single operand. Denormals are flushed
// to signed zero; the hidden bit is restored for normal numbers.
module fp_classify (
  input  logic [31:0] x,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] mant,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);

  logic [7:0]  efield;
  logic [22:0] frac;

  assign efield  = x[30:23];
  assign frac    = x[22:0];
  assign sign    = x[31];
  assign exp     = efield;
  assign is_zero = (efield == 8'h00);
  assign is_inf  = (efield == 8'hFF) && (frac == 23'd0);
  assign is_nan  = (efield == 8'hFF) && (frac != 23'd0);
  assign mant    = is_zero ? 24'd0 : {1'b1, frac};

endmodule

// File: rtl/fp_seq_unit.sv
// Multi-cycle FADD/FSUB/FMUL: one 26-bit adder and 1-bit/cycle shifting are
// time-shared across align, add, shift-add multiply and normalize states.
module fp_seq_unit
  import fp_pkg::*;
#(
  parameter int ALIGN_CAP = ALIGN_CAP_DEF,
  parameter int MUL_STEPS = MUL_STEPS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sx_q, sx_d, sy_q, sy_d, sign_q, sign_d;
  logic [25:0]        mx_q, mx_d, my_q, my_d, mant_q, mant_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [47:0]        prod_q, prod_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               spec_q, spec_d, zero_q, zero_d;
  logic [31:0]        spec_res_q, spec_res_d, res_q, res_d;
  logic [2:0]         spec_flg_q, spec_flg_d, flg_q, flg_d;

  logic        ca_sign, cb_sign, ca_zero, cb_zero, ca_inf, cb_inf, ca_nan, cb_nan;
  logic [7:0]  ca_exp, cb_exp;
  logic [23:0] ca_mant, cb_mant;

  fp_classify u_cls_a (.x(a_q), .sign(ca_sign), .exp(ca_exp), .mant(ca_mant),
                       .is_zero(ca_zero), .is_inf(ca_inf), .is_nan(ca_nan));
  fp_classify u_cls_b (.x(b_q), .sign(cb_sign), .exp(cb_exp), .mant(cb_mant),
                       .is_zero(cb_zero), .is_inf(cb_inf), .is_nan(cb_nan));

  logic              sbe, sm, a_big;
  logic signed [9:0] ediff;
  logic [9:0]        absd;
  logic [4:0]        dcl;

  assign sbe   = cb_sign ^ (op_q == OP_SUB);
  assign sm    = ca_sign ^ cb_sign;
  assign ediff = $signed({2'b00, ca_exp}) - $signed({2'b00, cb_exp});
  assign a_big = (ediff >= 10'sd0);
  assign absd  = a_big ? ediff : -ediff;
  assign dcl   = (absd > 10'(ALIGN_CAP)) ? 5'(ALIGN_CAP) : absd[4:0];

  // Special-case detection; only consumed in UNPACK.
  logic        sp_hit;
  logic [31:0] sp_res;
  logic [2:0]  sp_flg;

  always_comb begin
    sp_hit          = 1'b1;
    sp_res          = QNAN;
    sp_flg          = '0;
    sp_flg[FLG_INV] = 1'b1;
    if (op_q == 2'b11 || ca_nan || cb_nan) begin
      sp_hit = 1'b1;
    end else if (op_q == OP_MUL) begin
      if ((ca_inf && cb_zero) || (ca_zero && cb_inf)) begin
        sp_hit = 1'b1;
      end else if (ca_inf || cb_inf) begin
        sp_res = {sm, 8'hFF, 23'd0};
        sp_flg = '0;
      end else if (ca_zero || cb_zero) begin
        sp_res = {sm, 31'd0};
        sp_flg = '0;
      end else begin
        sp_hit = 1'b0;
      end
    end else begin
      if (ca_inf && cb_inf && (ca_sign != sbe)) begin
        sp_hit = 1'b1;
      end else if (ca_inf) begin
        sp_res = {ca_sign, 8'hFF, 23'd0};
        sp_flg = '0;
      end else if (cb_inf) begin
        sp_res = {sbe, 8'hFF, 23'd0};
        sp_flg = '0;
      end else begin
        sp_hit = 1'b0;
      end
    end
  end

  // Shared mantissa adder.
  logic [25:0] add_x, add_y, sum;
  logic        add_sub;
  assign sum = add_sub ? (add_x - add_y) : (add_x + add_y);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    sign_d     = sign_q;
    mx_d       = mx_q;
    my_d       = my_q;
    mant_d     = mant_q;
    exp_d      = exp_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    spec_d     = spec_q;
    zero_d     = zero_q;
    spec_res_d = spec_res_q;
    spec_flg_d = spec_flg_q;
    res_d      = res_q;
    flg_d      = flg_q;
    add_x      = '0;
    add_y      = '0;
    add_sub    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        op_d    = op;
        spec_d  = 1'b0;
        zero_d  = 1'b0;
        state_d = S_UNPACK;
      end
      S_UNPACK: begin
        if (op_q == OP_MUL) begin
          sign_d  = sm;
          exp_d   = 10'(ca_exp) + 10'(cb_exp) - 10'(BIAS);
          prod_d  = {24'd0, ca_mant};
          my_d    = {2'b00, cb_mant};
          cnt_d   = 5'(MUL_STEPS);
          state_d = S_MUL;
        end else begin
          // x keeps the larger exponent; y is the one that gets aligned
          sx_d    = a_big ? ca_sign : sbe;
          sy_d    = a_big ? sbe : ca_sign;
          mx_d    = {2'b00, a_big ? ca_mant : cb_mant};
          my_d    = {2'b00, a_big ? cb_mant : ca_mant};
          exp_d   = $signed({2'b00, a_big ? ca_exp : cb_exp});
          cnt_d   = dcl;
          state_d = (dcl == 5'd0) ? S_ADD : S_ALIGN;
        end
        if (sp_hit) begin
          spec_d     = 1'b1;
          spec_res_d = sp_res;
          spec_flg_d = sp_flg;
          state_d    = S_PACK;
        end
      end
      S_ALIGN: begin
        my_d  = my_q >> 1;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_ADD;
      end
      S_ADD: begin
        add_sub = sx_q ^ sy_q;
        add_x   = (mx_q >= my_q) ? mx_q : my_q;
        add_y   = (mx_q >= my_q) ? my_q : mx_q;
        sign_d  = (add_sub && (my_q > mx_q)) ? sy_q : sx_q;
        mant_d  = sum;
        if (sum == 26'd0) begin
          zero_d  = 1'b1;
          sign_d  = 1'b0;
          state_d = S_PACK;
        end else if (sum[24]) begin
          mant_d  = sum >> 1;
          exp_d   = exp_q + 10'sd1;
          state_d = S_PACK;
        end else begin
          state_d = sum[23] ? S_PACK : S_NORM;
        end
      end
      S_MUL: begin
        add_x   = {2'b00, prod_q[47:24]};
        add_y   = prod_q[0] ? my_q : 26'd0;
        prod_d  = {sum[24:0], prod_q[23:1]};
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_NORM;
      end
      S_NORM: begin
        if (op_q == OP_MUL) begin
          // product of two normal mantissas lies in [1,4)
          if (prod_q[47]) begin
            mant_d = {2'b00, prod_q[47:24]};
            exp_d  = exp_q + 10'sd1;
          end else begin
            mant_d = {2'b00, prod_q[46:23]};
          end
          state_d = S_PACK;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 10'sd1;
          if (mant_d[23] || exp_d <= 10'sd0) state_d = S_PACK;
        end
      end
      S_PACK: begin
        flg_d = '0;
        if (spec_q) begin
          res_d = spec_res_q;
          flg_d = spec_flg_q;
        end else if (zero_q) begin
          res_d = {sign_q, 31'd0};
        end else if (exp_q >= 10'sd255) begin
          res_d          = {sign_q, 8'hFF, 23'd0};
          flg_d[FLG_OVF] = 1'b1;
        end else if (exp_q <= 10'sd0) begin
          res_d          = {sign_q, 31'd0};
          flg_d[FLG_UNF] = 1'b1;
        end else begin
          res_d = {sign_q, exp_q[7:0], mant_q[22:0]};
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sx_q       <= 1'b0;
      sy_q       <= 1'b0;
      sign_q     <= 1'b0;
      mx_q       <= '0;
      my_q       <= '0;
      mant_q     <= '0;
      exp_q      <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      zero_q     <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
      res_q      <= '0;
      flg_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      sign_q     <= sign_d;
      mx_q       <= mx_d;
      my_q       <= my_d;
      mant_q     <= mant_d;
      exp_q      <= exp_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      spec_q     <= spec_d;
      zero_q     <= zero_d;
      spec_res_q <= spec_res_d;
      spec_flg_q <= spec_flg_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
    end
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign flags  = flg_q;

endmodule

// File: tb/tb_fp_seq_unit.sv
// Directed bench for fp_seq_unit: results, flags, latency, busy/done framing,
// start filtering, result hold and synchronous reset.
module tb_fp_seq_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
  } vec_t;

  fp_seq_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  // Issues one op and waits (bounded) for done; lat = -1 on timeout.
  // poke_at > 0 re-asserts start with other operands in that busy cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input int poke_at, output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    @(negedge clk);
    op = o; a = xa; b = xb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    for (int c = 1; c <= 200; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      start = (c == poke_at);
      if (c == poke_at) begin
        op = 2'b00; a = 32'h3F80_0000; b = 32'h3F80_0000;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", busy, done);
    end
    checks++;
    if (result !== 32'h0 || flags !== 3'b000) begin
      errors++;
      $display("FAIL reset_data: result=%h flags=%b, required 00000000 000", result, flags);
    end
    reset = 1'b0;
  endtask

  task automatic test_addsub;
    vec_t v[5];
    int lat;
    bit bok;
    v[0] = '{2'b00, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, 4};
    v[1] = '{2'b01, 32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 3'b000, 7};
    v[2] = '{2'b01, 32'h3F40_0000, 32'h3F80_0000, 32'hBE80_0000, 3'b000, 7};
    v[3] = '{2'b00, 32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 3'b000, 30};
    v[4] = '{2'b01, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000, 4};
    for (int i = 0; i < 5; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, 0, lat, bok);
      checks++;
      if (result !== v[i].res) begin
        errors++;
        $display("FAIL addsub[%0d] result: got %h, required %h", i, result, v[i].res);
      end
      checks++;
      if (flags !== v[i].flg) begin
        errors++;
        $display("FAIL addsub[%0d] flags: got %b, required %b", i, flags, v[i].flg);
      end
      checks++;
      if (lat !== v[i].lat) begin
        errors++;
        $display("FAIL addsub[%0d] latency: got %0d, required %0d", i, lat, v[i].lat);
      end
      checks++;
      if (!bok) begin
        errors++;
        $display("FAIL addsub[%0d] busy: dropped before done, required high", i);
      end
    end
  endtask

  task automatic test_mul;
    int lat;
    bit bok;
    do_op(2'b10, 32'h3FC0_0000, 32'h4000_0000, 10, lat, bok);
    checks++;
    if (result !== 32'h4040_0000 || flags !== 3'b000) begin
      errors++;
      $display("FAIL mul result: got %h/%b, required 40400000/000", result, flags);
    end
    checks++;
    if (lat !== 28) begin
      errors++;
      $display("FAIL mul latency: got %0d, required 28", lat);
    end
    checks++;
    if (!bok) begin
      errors++;
      $display("FAIL mul busy: dropped before done, required high");
    end
    // start raised in the DONE cycle must be ignored; result must hold
    op = 2'b00; a = 32'h3F80_0000; b = 32'h3F80_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h4040_0000) begin
        errors++;
        $display("FAIL mul_hold[%0d]: busy=%b done=%b result=%h, required 0 0 40400000",
                 i, busy, done, result);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_specials;
    vec_t v[7];
    int lat;
    bit bok;
    v[0] = '{2'b01, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b100, 3};
    v[1] = '{2'b10, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100, 3};
    v[2] = '{2'b10, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b010, 28};
    v[3] = '{2'b10, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b001, 28};
    v[4] = '{2'b00, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 3'b000, 3};
    v[5] = '{2'b11, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b100, 3};
    v[6] = '{2'b00, 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100, 3};
    for (int i = 0; i < 7; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, 0, lat, bok);
      checks++;
      if (result !== v[i].res) begin
        errors++;
        $display("FAIL special[%0d] result: got %h, required %h", i, result, v[i].res);
      end
      checks++;
      if (flags !== v[i].flg) begin
        errors++;
        $display("FAIL special[%0d] flags: got %b, required %b", i, flags, v[i].flg);
      end
      checks++;
      if (lat !== v[i].lat) begin
        errors++;
        $display("FAIL special[%0d] latency: got %0d, required %0d", i, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit bok;
    @(negedge clk);
    op = 2'b10; a = 32'h3FC0_0000; b = 32'h4000_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || flags !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h flags=%b, required 0 0 00000000 000",
               busy, done, result, flags);
    end
    do_op(2'b00, 32'h3F80_0000, 32'h3F80_0000, 0, lat, bok);
    checks++;
    if (result !== 32'h4000_0000 || lat !== 4) begin
      errors++;
      $display("FAIL after_reset: result=%h lat=%0d, required 40000000 4", result, lat);
    end
  endtask

  initial begin
    test_reset;
    test_addsub;
    test_mul;
    test_specials;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
